// File: rtl/fp_accum.sv
// -----------------------------------------------------------------------------
// fp_accum -- streaming floating-point vector accumulator
//
// Sums a vector of IEEE-754 single-precision elements using an external
// combinational FP adder. The first element of a vector is loaded directly
// into the accumulator; every following element is added to the running sum.
// After the element flagged with in_last is accepted, the result is held on
// out_data with out_vld high until the downstream accepts it.
//
// Elements whose exponent field is zero are treated as zero: they are counted
// but do not alter the accumulator.
//
// Ports:
//   clk       in   sole clock, rising edge
//   rst       in   synchronous active-high reset
//   in_vld    in   upstream element valid
//   in_data   in   [31:0] FP element {sign, exp[7:0], mantissa[22:0]}
//   in_last   in   final element of the vector (qualified by in_vld)
//   in_rdy    out  element accepted when in_vld & in_rdy
//   add_a     out  [31:0] adder operand A (accumulator register)
//   add_b     out  [31:0] adder operand B (in_data passthrough)
//   add_sum   in   [31:0] adder result, combinational from add_a/add_b
//   out_vld   out  accumulated result valid
//   out_data  out  [31:0] accumulated result
//   out_rdy   in   downstream accepts when out_vld & out_rdy
//   count     out  [9:0] elements accepted in the current vector (saturates)
//
// Configuration:
//   FP_ACCUM_RELU_EN  when defined, out_data reads as zero whenever the
//                     accumulator is negative.
// -----------------------------------------------------------------------------
module fp_accum (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_vld,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        in_rdy,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic [31:0] add_sum,
    output logic        out_vld,
    output logic [31:0] out_data,
    input  logic        out_rdy,
    output logic [9:0]  count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam logic [9:0] COUNT_MAX = 10'd1023;

    state_e      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [9:0]  count_q, count_d;
    logic        in_rdy_q, in_rdy_d;
    logic        out_vld_q, out_vld_d;

    logic accept;
    logic in_is_zero;

    assign accept     = in_vld & in_rdy_q;
    assign in_is_zero = (in_data[30:23] == 8'h00);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    // First element bypasses the adder; a zero-exponent first
                    // element starts the sum at a clean +0.
                    acc_d   = in_is_zero ? 32'h0000_0000 : in_data;
                    count_d = 10'd1;
                    state_d = in_last ? HOLD : ACC;
                end
            end
            ACC: begin
                if (accept) begin
                    if (!in_is_zero) begin
                        acc_d = add_sum;
                    end
                    // Keep counting-through at the top value; the sum itself
                    // keeps accumulating.
                    count_d = (count_q == COUNT_MAX) ? count_q : count_q + 10'd1;
                    state_d = in_last ? HOLD : ACC;
                end
            end
            HOLD: begin
                if (out_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake outputs are registered and derived from the next state so
        // they line up with the state they describe.
        in_rdy_d  = (state_d != HOLD);
        out_vld_d = (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= 32'h0000_0000;
            count_q   <= 10'd0;
            in_rdy_q  <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            in_rdy_q  <= in_rdy_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign in_rdy  = in_rdy_q;
    assign out_vld = out_vld_q;
    assign count   = count_q;
    assign add_a   = acc_q;
    assign add_b   = in_data;

`ifdef FP_ACCUM_RELU_EN
    assign out_data = acc_q[31] ? 32'h0000_0000 : acc_q;
`else
    assign out_data = acc_q;
`endif

endmodule

// File: tb/tb_fp_accum.sv
// -----------------------------------------------------------------------------
// tb_fp_accum -- directed self-checking bench for fp_accum
//
// The external FP adder is modelled by a small table of hand-computed sums for
// the operand pairs the stimulus produces; any other pair yields a poison
// value so a wrongly routed adder result is visible on out_data.
// -----------------------------------------------------------------------------
module tb_fp_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_vld;
    logic [31:0] in_data;
    logic        in_last;
    logic        in_rdy;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] add_sum;
    logic        out_vld;
    logic [31:0] out_data;
    logic        out_rdy;
    logic [9:0]  count;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [31:0] POISON = 32'hDEAD_BEEF;

    always #5 clk = ~clk;

    fp_accum dut (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (in_vld),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_rdy   (in_rdy),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_sum  (add_sum),
        .out_vld  (out_vld),
        .out_data (out_data),
        .out_rdy  (out_rdy),
        .count    (count)
    );

    function automatic logic [31:0] fp_add_lut(input logic [31:0] a, input logic [31:0] b);
        if      (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000; // 1 + 2
        else if (a == 32'h3F80_0000 && b == 32'hC000_0000) return 32'hBF80_0000; // 1 - 2
        else if (a == 32'h0000_0000 && b == 32'h4040_0000) return 32'h4040_0000; // 0 + 3
        else return POISON;
    endfunction

    assign add_sum = fp_add_lut(add_a, add_b);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] data, input logic last);
        in_vld  = 1'b1;
        in_data = data;
        in_last = last;
        step();
        in_vld  = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic release_out();
        out_rdy = 1'b1;
        step();
        out_rdy = 1'b0;
    endtask

    logic [31:0] exp_neg;

    initial begin
        rst     = 1'b1;
        in_vld  = 1'b0;
        in_data = 32'h0;
        in_last = 1'b0;
        out_rdy = 1'b0;

        // ---------------- reset ----------------
        step();
        step();
        check("rst_in_rdy",  {31'b0, in_rdy},  32'd0);
        check("rst_out_vld", {31'b0, out_vld}, 32'd0);
        check("rst_count",   {22'b0, count},   32'd0);
        check("rst_add_a",   add_a,            32'h0);
        rst = 1'b0;
        step();
        check("post_rst_in_rdy", {31'b0, in_rdy}, 32'd1);

        // ---------------- 1.0 + 2.0 ----------------
        send(32'h3F80_0000, 1'b0);
        check("v1_count1",  {22'b0, count},   32'd1);
        check("v1_add_a",   add_a,            32'h3F80_0000);
        check("v1_out_vld0",{31'b0, out_vld}, 32'd0);
        in_data = 32'h4000_0000;
        #1;
        check("v1_add_b",   add_b,            32'h4000_0000);
        send(32'h4000_0000, 1'b1);
        check("v1_out_vld", {31'b0, out_vld}, 32'd1);
        check("v1_data",    out_data,         32'h4040_0000);
        check("v1_count",   {22'b0, count},   32'd2);
        check("v1_in_rdy0", {31'b0, in_rdy},  32'd0);
        release_out();
        check("v1_idle_vld",{31'b0, out_vld}, 32'd0);
        check("v1_idle_rdy",{31'b0, in_rdy},  32'd1);

        // ---------------- single element, adder bypassed ----------------
        send(32'h3F00_0000, 1'b1);
        check("v2_out_vld", {31'b0, out_vld}, 32'd1);
        check("v2_data",    out_data,         32'h3F00_0000);
        check("v2_count",   {22'b0, count},   32'd1);
        release_out();

        // ---------------- 1.0 + (-2.0) ----------------
`ifdef FP_ACCUM_RELU_EN
        exp_neg = 32'h0000_0000;
`else
        exp_neg = 32'hBF80_0000;
`endif
        send(32'h3F80_0000, 1'b0);
        send(32'hC000_0000, 1'b1);
        check("v3_out_vld", {31'b0, out_vld}, 32'd1);
        check("v3_data",    out_data,         exp_neg);
        release_out();

        // ---------------- zero first element ----------------
        send(32'h0000_0000, 1'b0);
        check("v4_add_a",   add_a,            32'h0);
        send(32'h4040_0000, 1'b1);
        check("v4_data",    out_data,         32'h4040_0000);
        check("v4_count",   {22'b0, count},   32'd2);
        release_out();

        // ---------------- zero element in ACC leaves sum unchanged ----------
        send(32'h3F80_0000, 1'b0);
        send(32'h0012_3456, 1'b0);
        check("v5_add_a",   add_a,            32'h3F80_0000);
        send(32'h4000_0000, 1'b1);
        check("v5_data",    out_data,         32'h4040_0000);
        check("v5_count",   {22'b0, count},   32'd3);

        // ---------------- out_rdy held low in HOLD ----------------
        // An element is offered throughout; it must not be taken in HOLD or
        // in the cycle the result is released.
        in_vld  = 1'b1;
        in_data = 32'h4000_0000;
        in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_vld",   {31'b0, out_vld}, 32'd1);
            check("hold_data",  out_data,         32'h4040_0000);
            check("hold_count", {22'b0, count},   32'd3);
            check("hold_rdy",   {31'b0, in_rdy},  32'd0);
        end
        out_rdy = 1'b1;
        step();
        out_rdy = 1'b0;
        check("rel_out_vld", {31'b0, out_vld}, 32'd0);
        check("rel_in_rdy",  {31'b0, in_rdy},  32'd1);
        check("rel_count",   {22'b0, count},   32'd3);
        step();
        in_vld  = 1'b0;
        in_last = 1'b0;
        check("rel_next_vld",  {31'b0, out_vld}, 32'd1);
        check("rel_next_data", out_data,         32'h4000_0000);
        check("rel_next_cnt",  {22'b0, count},   32'd1);
        release_out();

        // ---------------- reset mid-vector ----------------
        send(32'h3F80_0000, 1'b0);
        send(32'h3F80_0000, 1'b0);
        send(32'h3F80_0000, 1'b0);
        check("mid_count3", {22'b0, count}, 32'd3);
        rst = 1'b1;
        step();
        check("mid_rst_count", {22'b0, count},   32'd0);
        check("mid_rst_vld",   {31'b0, out_vld}, 32'd0);
        check("mid_rst_rdy",   {31'b0, in_rdy},  32'd0);
        rst = 1'b0;
        step();
        check("mid_post_vld",  {31'b0, out_vld}, 32'd0);
        send(32'h4000_0000, 1'b1);
        check("mid_new_data",  out_data,         32'h4000_0000);
        check("mid_new_count", {22'b0, count},   32'd1);
        release_out();

        // ---------------- in_last ignored without in_vld; count saturation --
        send(32'h3F80_0000, 1'b0);
        in_last = 1'b1;
        step();
        in_last = 1'b0;
        check("last_no_vld", {31'b0, out_vld}, 32'd0);
        for (int i = 0; i < 1023; i++) begin
            send(32'h0012_3456, 1'b0);
        end
        check("sat_count_pre", {22'b0, count}, 32'd1023);
        send(32'h0000_0001, 1'b1);
        check("sat_vld",   {31'b0, out_vld}, 32'd1);
        check("sat_count", {22'b0, count},   32'd1023);
        check("sat_data",  out_data,         32'h3F80_0000);
        release_out();
        check("sat_idle",  {31'b0, out_vld}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_accum.md
FP_ACCUM -- requirements
Module: fp_accum

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port in_vld, input, 1, upstream element valid.
REQ-004 SHALL have port in_data, input, 32, FP element {sign, 8-bit exp, 23-bit mantissa}.
REQ-005 SHALL have port in_last, input, 1, marks final element of vector; qualified by in_vld.
REQ-006 SHALL have port in_rdy, output, 1, element accepted when in_vld & in_rdy.
REQ-007 SHALL have port add_a, output, 32, operand A to external combinational FP adder (running accumulator).
REQ-008 SHALL have port add_b, output, 32, operand B to FP adder (in_data passthrough).
REQ-009 SHALL have port add_sum, input, 32, FP adder result, valid same cycle as add_a/add_b.
REQ-010 SHALL have port out_vld, output, 1, accumulated result valid.
REQ-011 SHALL have port out_data, output, 32, accumulated FP result.
REQ-012 SHALL have port out_rdy, input, 1, downstream accepts when out_vld & out_rdy.
REQ-013 SHALL have port count, output, 10, elements accepted in current vector.

Function
REQ-014 SHALL implement states IDLE, ACC, HOLD; IDLE after reset.
REQ-015 SHALL drive in_rdy = 1 in IDLE and ACC, 0 in HOLD.
REQ-016 SHALL, on acceptance in IDLE, load accumulator directly with in_data (adder bypassed), set count = 1, go to ACC (or HOLD if in_last).
REQ-017 SHALL, on acceptance in ACC, load accumulator with add_sum, increment count, stay in ACC (or go to HOLD if in_last).
REQ-018 SHALL treat any element with exponent field 8'h00 as zero: accumulator unchanged, count still incremented, in_last still honoured.
REQ-019 SHALL, in IDLE with a zero-exponent first element, load accumulator with 32'h00000000.
REQ-020 SHALL sustain one element per cycle; no bubbles in ACC while in_vld held high.
REQ-021 SHALL assert out_vld exactly in HOLD, first cycle being the one after in_last acceptance (latency 1).
REQ-022 SHALL hold out_data and count stable while out_vld & ~out_rdy.
REQ-023 SHALL, on out_vld & out_rdy, go to IDLE next cycle; no element accepted in that cycle.
REQ-024 SHALL saturate count at 1023; further elements still accumulate.
REQ-025 SHALL drive add_a = accumulator register and add_b = in_data combinationally in all states.
REQ-026 SHALL ignore in_last when in_vld is low.

Reset
REQ-027 SHALL on rst: state = IDLE, accumulator = 32'h00000000, count = 0, out_vld = 0, in_rdy = 0 during the reset cycle, 1 from the first cycle after rst deasserts.
REQ-028 SHALL discard any partial vector when rst asserts mid-operation (ACC or HOLD); no out_vld afterwards for that vector.

Configuration
REQ-029 SHALL, when FP_ACCUM_RELU_EN is defined, force out_data = 32'h00000000 whenever the accumulator sign bit is 1.
REQ-030 SHALL, when FP_ACCUM_RELU_EN is undefined, present the accumulator unmodified on out_data.

Verification
REQ-031 SHALL cover: 0x3F800000, 0x40000000(last), out_rdy=1 -> out_vld next cycle, out_data=0x40400000, count=2.
REQ-032 SHALL cover: single element 0x3F000000 with in_last -> out_data=0x3F000000, count=1, adder result ignored.
REQ-033 SHALL cover: 0x3F800000, 0xC0000000(last) -> out_data=0xBF800000 without macro, 0x00000000 with FP_ACCUM_RELU_EN.
REQ-034 SHALL cover: 0x00000000, 0x40400000(last) -> out_data=0x40400000, count=2.
REQ-035 SHALL cover: out_rdy low 5 cycles in HOLD -> out_vld, out_data, count stable, in_rdy=0; release -> IDLE next cycle.
REQ-036 SHALL cover: rst pulse after 3 elements in ACC -> count=0, out_vld=0; fresh vector 0x40000000(last) -> out_data=0x40000000.
